// File: rtl/traffic_pkg.sv
// Shared encodings and default timings for the intersection scheduler.
package traffic_pkg;

  // Phase encoding; values are visible on the debug phase port.
  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    ALL_RED  = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    PED_WALK = 3'd5
  } state_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam int CNT_W_DEF     = 11;
  localparam int GREEN_MIN_DEF = 1023;
  localparam int YELLOW_T_DEF  = 511;
  localparam int ALLRED_T_DEF  = 127;
  localparam int WALK_T_DEF    = 511;

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts cycles spent in the current phase, cleared on phase
// entry, holds once it reaches lim.
module phase_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] count
);

  // Clear has priority; otherwise count up until the limit is reached.
  always_ff @(posedge clk) begin
    if (rst || clr)        count <= '0;
    else if (count != lim) count <= count + 1'b1;
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection phase sequencer with pedestrian walk phase.
// Optional feature: define EMERG_PREEMPT_EN to add emergency preemption
// (emerg_req / emerg_dir ports).
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF,
  parameter int WALK_T    = WALK_T_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_req_ns,
  input  logic       car_req_ew,
  input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
  input  logic       emerg_req,
  input  logic       emerg_dir,
`endif
  output logic       ns_r,
  output logic       ns_y,
  output logic       ns_g,
  output logic       ew_r,
  output logic       ew_y,
  output logic       ew_g,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WALK_T - 1);

  state_t           state, state_nxt;
  logic             next_dir, dir_nxt;
  logic             ped_pending, ped_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] tim_lim;
  logic             tim_clr;
  logic             em_ns, em_ew, em_any;

`ifdef EMERG_PREEMPT_EN
  assign em_ns = emerg_req && (emerg_dir == DIR_NS);
  assign em_ew = emerg_req && (emerg_dir == DIR_EW);
`else
  assign em_ns = 1'b0;
  assign em_ew = 1'b0;
`endif
  assign em_any = em_ns || em_ew;

  // Greens saturate at the minimum so a resting green can yield immediately
  // once demand shows up; other phases never reach the counter ceiling.
  assign tim_lim = (state == NS_G || state == EW_G) ? G_LAST : '1;
  assign tim_clr = (state_nxt != state);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tim_clr),
    .lim   (tim_lim),
    .count (timer)
  );

  // Next-phase selection and direction bookkeeping.
  always_comb begin
    state_nxt = state;
    dir_nxt   = next_dir;
    case (state)
      NS_G: begin
        if (em_ew)
          state_nxt = NS_Y;
        else if (!em_ns && timer == G_LAST && (car_req_ew || ped_pending))
          state_nxt = NS_Y;
      end
      NS_Y: begin
        if (timer == Y_LAST) begin
          state_nxt = ALL_RED;
          dir_nxt   = DIR_EW;
        end
      end
      EW_G: begin
        if (em_ns)
          state_nxt = EW_Y;
        else if (!em_ew && timer == G_LAST && (car_req_ns || ped_pending))
          state_nxt = EW_Y;
      end
      EW_Y: begin
        if (timer == Y_LAST) begin
          state_nxt = ALL_RED;
          dir_nxt   = DIR_NS;
        end
      end
      ALL_RED: begin
        if (timer == AR_LAST) begin
          if (em_any)           state_nxt = em_ew ? EW_G : NS_G;
          else if (ped_pending) state_nxt = PED_WALK;
          else                  state_nxt = (next_dir == DIR_EW) ? EW_G : NS_G;
        end
      end
      PED_WALK: begin
        if (em_any)
          state_nxt = ALL_RED;
        else if (timer == W_LAST)
          state_nxt = (next_dir == DIR_EW) ? EW_G : NS_G;
      end
      default: begin
        state_nxt = ALL_RED;
        dir_nxt   = DIR_NS;
      end
    endcase
  end

  // Pedestrian latch: clear on walk entry beats a coincident press.
  always_comb begin
    ped_nxt = ped_pending || (ped_req && state != PED_WALK);
    if (state_nxt == PED_WALK && state != PED_WALK) ped_nxt = 1'b0;
  end

  // Phase register with lamps decoded from the next phase so they are
  // registered and move together with the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NS_G;
      next_dir    <= DIR_EW;
      ped_pending <= 1'b0;
      ns_r        <= 1'b0;
      ns_y        <= 1'b0;
      ns_g        <= 1'b1;
      ew_r        <= 1'b1;
      ew_y        <= 1'b0;
      ew_g        <= 1'b0;
      ped_walk    <= 1'b0;
      phase       <= NS_G;
    end else begin
      state       <= state_nxt;
      next_dir    <= dir_nxt;
      ped_pending <= ped_nxt;
      ns_g        <= (state_nxt == NS_G);
      ns_y        <= (state_nxt == NS_Y);
      ns_r        <= (state_nxt != NS_G) && (state_nxt != NS_Y);
      ew_g        <= (state_nxt == EW_G);
      ew_y        <= (state_nxt == EW_Y);
      ew_r        <= (state_nxt != EW_G) && (state_nxt != EW_Y);
      ped_walk    <= (state_nxt == PED_WALK);
      phase       <= state_nxt;
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: phase-level model checked every cycle,
// plus directed scenarios with hand-computed phase boundaries.
module tb_intersection_scheduler;

  localparam int GMIN = 1023;
  localparam int YT   = 511;
  localparam int ART  = 127;
  localparam int WT   = 511;

  localparam int P_NSG = 0, P_NSY = 1, P_AR = 2, P_EWG = 3, P_EWY = 4, P_WALK = 5;

  // Selector codes for wait_n
  localparam int S_NSG = 0, S_NSY = 1, S_AR = 2, S_EWG = 3, S_WALK = 4, S_EWY = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic car_req_ns = 1'b0, car_req_ew = 1'b0, ped_req = 1'b0;
`ifdef EMERG_PREEMPT_EN
  logic emerg_req = 1'b0, emerg_dir = 1'b0;
`endif
  logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  bit chk_en = 1'b0;

  intersection_scheduler #(
    .CNT_W(11), .GREEN_MIN(GMIN), .YELLOW_T(YT), .ALLRED_T(ART), .WALK_T(WT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .car_req_ns (car_req_ns),
    .car_req_ew (car_req_ew),
    .ped_req    (ped_req),
`ifdef EMERG_PREEMPT_EN
    .emerg_req  (emerg_req),
    .emerg_dir  (emerg_dir),
`endif
    .ns_r       (ns_r),
    .ns_y       (ns_y),
    .ns_g       (ns_g),
    .ew_r       (ew_r),
    .ew_y       (ew_y),
    .ew_g       (ew_g),
    .ped_walk   (ped_walk),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Lamp pattern per phase: {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk}
  function automatic logic [6:0] lamps(input int ph);
    case (ph)
      P_NSG:   return 7'b0011000;
      P_NSY:   return 7'b0101000;
      P_AR:    return 7'b1001000;
      P_EWG:   return 7'b1000010;
      P_EWY:   return 7'b1000100;
      P_WALK:  return 7'b1001001;
      default: return 7'b0000000;
    endcase
  endfunction

  // ---------------- phase-level model ----------------
  int m_ph = P_NSG, m_el = 0, m_dir = 1, nph = 0, ndir = 0;
  bit m_ped = 1'b0, em = 1'b0, emd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_NSG; m_el = 0; m_dir = 1; m_ped = 1'b0;
    end else begin
      em = 1'b0; emd = 1'b0;
`ifdef EMERG_PREEMPT_EN
      em = emerg_req; emd = emerg_dir;
`endif
      nph = m_ph; ndir = m_dir;
      case (m_ph)
        P_NSG:  if (em) begin if (emd) nph = P_NSY; end
                else if (m_el >= GMIN - 1 && (car_req_ew || m_ped)) nph = P_NSY;
        P_EWG:  if (em) begin if (!emd) nph = P_EWY; end
                else if (m_el >= GMIN - 1 && (car_req_ns || m_ped)) nph = P_EWY;
        P_NSY:  if (m_el + 1 == YT) begin nph = P_AR; ndir = 1; end
        P_EWY:  if (m_el + 1 == YT) begin nph = P_AR; ndir = 0; end
        P_AR:   if (m_el + 1 == ART)
                  nph = em ? (emd ? P_EWG : P_NSG) : (m_ped ? P_WALK : (m_dir == 1 ? P_EWG : P_NSG));
        P_WALK: if (em) nph = P_AR;
                else if (m_el + 1 == WT) nph = (m_dir == 1) ? P_EWG : P_NSG;
        default: nph = P_AR;
      endcase
      if (nph == P_WALK && m_ph != P_WALK) m_ped = 1'b0;
      else if (ped_req && m_ph != P_WALK)  m_ped = 1'b1;
      m_el  = (nph != m_ph) ? 0 : m_el + 1;
      m_ph  = nph;
      m_dir = ndir;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk} !== lamps(m_ph) || phase !== 3'(m_ph)) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model cyc %0d: lamps %b phase %0d, expected lamps %b phase %0d",
                   cyc, {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk}, phase, lamps(m_ph), m_ph);
      end
      checks++;
      if (!(ns_r || ew_r) || (ns_r + ns_y + ns_g != 1) || (ew_r + ew_y + ew_g != 1)) begin
        errors++;
        if (errors <= 20)
          $display("FAIL safety cyc %0d: ns %b%b%b ew %b%b%b, expected one-hot heads with a red",
                   cyc, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic sel(input int w);
    case (w)
      S_NSG:   return ns_g;
      S_NSY:   return ns_y;
      S_AR:    return ns_r && ew_r && !ped_walk;
      S_EWG:   return ew_g;
      S_WALK:  return ped_walk;
      S_EWY:   return ew_y;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) for a lamp condition; check the cycle it first appears.
  task automatic wait_n(input int w, input int exp_n, input string nm);
    while (!sel(w) && (cyc - base) < exp_n + 50) @(negedge clk);
    checks++;
    if (!sel(w) || (cyc - base) != exp_n) begin
      errors++;
      $display("FAIL %s: seen=%0d at cycle %0d, expected at cycle %0d", nm, sel(w), cyc - base, exp_n);
    end
  endtask

  task automatic chk(input logic cond, input string nm, input int act, input int exp);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk} == 7'b0011000 && phase == 3'd0,
        "reset_state", int'({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk}), int'(7'b0011000));
    rst  = 1'b0;
    base = cyc;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // 1: idle rests in N-S green
    do_reset();
    repeat (5000) @(negedge clk);
    chk(ns_g && ew_r && !ped_walk, "idle_ns_green", int'({ns_g, ew_r, ped_walk}), 6);

    // 2: held E-W demand
    car_req_ew = 1'b1;
    do_reset();
    wait_n(S_NSY, GMIN, "dem_ns_yellow");
    wait_n(S_AR, GMIN + YT, "dem_all_red");
    wait_n(S_EWG, GMIN + YT + ART, "dem_ew_green");
    car_req_ew = 1'b0;

    // 3/4: pedestrian call, second press during walk ignored
    do_reset();
    while (cyc - base < 100) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_n(S_NSY, GMIN, "ped_ns_yellow");
    wait_n(S_WALK, GMIN + YT + ART, "ped_walk_start");
    repeat (20) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_n(S_EWG, GMIN + YT + ART + WT, "ped_ew_green");
    chk(dut.ped_pending == 1'b0, "ped_pending_clear", int'(dut.ped_pending), 0);
    repeat (3000) @(negedge clk);
    chk(ew_g && !ped_walk, "no_second_walk", int'({ew_g, ped_walk}), 2);

    // 5: reset in the middle of N-S yellow
    car_req_ew = 1'b1;
    do_reset();
    wait_n(S_NSY, GMIN, "rst_ns_yellow");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk} == 7'b0011000 && phase == 3'd0,
        "midrst_state", int'(phase), 0);
    rst  = 1'b0;
    base = cyc;
    wait_n(S_NSY, GMIN, "midrst_restart_min");
    car_req_ew = 1'b0;

`ifdef EMERG_PREEMPT_EN
    // 6: preemption toward N-S while E-W is green
    car_req_ew = 1'b1;
    do_reset();
    wait_n(S_EWG, GMIN + YT + ART, "em_reach_ew");
    car_req_ew = 1'b0;
    repeat (30) @(negedge clk);
    emerg_req = 1'b1;
    emerg_dir = 1'b0;
    base = cyc;
    wait_n(S_EWY, 1, "em_ew_yellow");
    wait_n(S_NSG, 1 + YT + ART, "em_ns_green");
    car_req_ew = 1'b1;
    repeat (2000) @(negedge clk);
    chk(ns_g == 1'b1, "em_ns_hold", int'(ns_g), 1);
    emerg_req = 1'b0;
    repeat (200) @(negedge clk);
    car_req_ew = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
